// File: rtl/string_sequencer.sv
// String sequencer: walks a message slot in memory and feeds each
// character to a transmitter with a start/busy handshake.
module string_sequencer #(
   parameter int                DATA_W  = 8,
   parameter int                ADDR_W  = 6,
   parameter int                N_MSG   = 4,
   parameter int                MAX_LEN = 16,
   parameter logic [DATA_W-1:0] TERM    = '0,
   localparam int SEL_W = (N_MSG > 1) ? $clog2(N_MSG) : 1,
   localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              trigger_i,
   input  logic [SEL_W-1:0]  msg_sel_i,
   input  logic              loop_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] address_o,
   input  logic [DATA_W-1:0] byte_i,
   output logic [DATA_W-1:0] data_o,
   output logic              start_o,
   input  logic              busy_i,
   output logic              active_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int OFF_W = $clog2(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_MEM,
      CHECK,
      SEND,
      WAIT_LO,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               abort_q, abort_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  data_d;
   logic [CNT_W-1:0]   cnt_d;
   logic [31:0]        sel_wide;
   logic               sel_ok;

   function automatic logic [ADDR_W-1:0] base_of(input logic [SEL_W-1:0] s);
      return ADDR_W'(s) << OFF_W;
   endfunction

   assign sel_wide = 32'(msg_sel_i);
   assign sel_ok   = sel_wide < 32'(N_MSG);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         abort_q   <= 1'b0;
         address_o <= '0;
         data_o    <= '0;
         count_o   <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         abort_q   <= abort_d;
         address_o <= addr_d;
         data_o    <= data_d;
         count_o   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      abort_d  = abort_q;
      addr_d   = address_o;
      data_d   = data_o;
      cnt_d    = count_o;
      start_o  = 1'b0;
      done_o   = 1'b0;
      active_o = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (trigger_i && !abort_i && sel_ok) begin
               sel_d   = msg_sel_i;
               addr_d  = base_of(msg_sel_i);
               cnt_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = abort_i ? IDLE : WAIT_MEM;
         end
         WAIT_MEM: begin
            state_d = abort_i ? IDLE : CHECK;
         end
         CHECK: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (byte_i == TERM || count_o == CNT_W'(MAX_LEN)) begin
               state_d = DONE;
            end else begin
               data_d  = byte_i;
               state_d = SEND;
            end
         end
         SEND: begin
            start_o = 1'b1;
            if (abort_i) abort_d = 1'b1;
            if (busy_i) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (abort_i) abort_d = 1'b1;
            if (!busy_i) begin
               cnt_d = count_o + CNT_W'(1);
               // address saturates on the last offset so it stays in the slot
               if (count_o != CNT_W'(MAX_LEN - 1)) begin
                  addr_d = address_o + ADDR_W'(1);
               end
               state_d = (abort_q || abort_i) ? IDLE : FETCH;
            end
         end
         DONE: begin
            done_o = 1'b1;
            if (loop_i && !abort_i) begin
               addr_d  = base_of(sel_q);
               cnt_d   = '0;
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
